// File: rtl/screen_sequencer.sv
// Screen controller for the maze game. It steps through the title, play, scare and win screens,
// chooses which RGB generator drives the pins, and cycles the title-text colour on frame ticks.
module screen_sequencer #(
    parameter int FRAMES_SCARE = 120,
    parameter int FRAMES_WIN   = 180,
    parameter int COLOR_FRAMES = 30,
    parameter int LEVELS       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       collision,
    input  logic       goal_reached,
    input  logic       video_on,
    input  logic [2:0] rgb_title,
    input  logic [2:0] rgb_maze,
    input  logic [2:0] rgb_scare,
    input  logic [2:0] rgb_win,
    output logic [2:0] rgb_out,
    output logic [2:0] title_color,
    output logic [1:0] state,
    output logic [1:0] level
);
    typedef enum logic [1:0] {
        TITLE = 2'b00,
        PLAY  = 2'b01,
        SCARE = 2'b10,
        WIN   = 2'b11
    } state_t;

    localparam logic [7:0] SCARE_LAST = 8'(FRAMES_SCARE - 1);
    localparam logic [7:0] WIN_LAST   = 8'(FRAMES_WIN - 1);
    localparam logic [7:0] COLOR_LAST = 8'(COLOR_FRAMES - 1);
    localparam logic [1:0] LEVEL_LAST = 2'(LEVELS - 1);

    state_t     cur, nxt;
    logic [1:0] level_nxt;
    logic       btn_q, armed, armed_nxt, start_edge;
    logic [7:0] fcnt, ccnt;
    logic [2:0] rgb_sel;

    assign start_edge = btn_start & ~btn_q;
    assign state      = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur   <= TITLE;
            level <= 2'd0;
        end else begin
            cur   <= nxt;
            level <= level_nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        level_nxt = level;
        // Any cycle with the goal low re-arms it; consuming a goal disarms it.
        armed_nxt = armed | ~goal_reached;
        case (cur)
            TITLE: begin
                if (start_edge) begin
                    nxt       = PLAY;
                    level_nxt = 2'd0;
                end
            end
            PLAY: begin
                if (collision) begin
                    nxt = SCARE;
                end else if (goal_reached && armed) begin
                    armed_nxt = 1'b0;
                    if (level == LEVEL_LAST) nxt = WIN;
                    else level_nxt = level + 2'd1;
                end
            end
            SCARE: begin
                if (frame_tick && fcnt == SCARE_LAST) begin
                    nxt       = TITLE;
                    level_nxt = 2'd0;
                end
            end
            WIN: begin
                if (frame_tick && fcnt == WIN_LAST) begin
                    nxt       = TITLE;
                    level_nxt = 2'd0;
                end
            end
            default: nxt = TITLE;
        endcase
    end

    always_comb begin
        case (cur)
            TITLE:   rgb_sel = rgb_title;
            PLAY:    rgb_sel = rgb_maze;
            SCARE:   rgb_sel = rgb_scare;
            default: rgb_sel = rgb_win;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q       <= 1'b0;
            armed       <= 1'b1;
            fcnt        <= 8'd0;
            ccnt        <= 8'd0;
            title_color <= 3'd1;
            rgb_out     <= 3'd0;
        end else begin
            btn_q   <= btn_start;
            armed   <= armed_nxt;
            rgb_out <= video_on ? rgb_sel : 3'd0;

            if (nxt != cur) fcnt <= 8'd0;
            else if (frame_tick && fcnt != 8'hFF) fcnt <= fcnt + 8'd1;

            // Holding ccnt at zero outside TITLE gives a fresh colour period on every entry.
            if (cur != TITLE) begin
                ccnt <= 8'd0;
            end else if (frame_tick) begin
                if (ccnt == COLOR_LAST) begin
                    ccnt        <= 8'd0;
                    title_color <= (title_color == 3'd7) ? 3'd1 : title_color + 3'd1;
                end else begin
                    ccnt <= ccnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed scenarios with literal expectations plus a long
// randomized run compared every cycle against a frame-counting behavioural model.
module tb_screen_sequencer;
    localparam int FRAMES_SCARE = 120;
    localparam int FRAMES_WIN   = 180;
    localparam int COLOR_FRAMES = 30;
    localparam int LEVELS       = 3;

    logic       clk = 1'b0, reset = 1'b1;
    logic       frame_tick = 0, btn_start = 0, collision = 0, goal_reached = 0, video_on = 0;
    logic [2:0] rgb_title = 0, rgb_maze = 0, rgb_scare = 0, rgb_win = 0;
    logic [2:0] rgb_out, title_color;
    logic [1:0] state, level;

    screen_sequencer #(
        .FRAMES_SCARE(FRAMES_SCARE), .FRAMES_WIN(FRAMES_WIN),
        .COLOR_FRAMES(COLOR_FRAMES), .LEVELS(LEVELS)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start),
        .collision(collision), .goal_reached(goal_reached), .video_on(video_on),
        .rgb_title(rgb_title), .rgb_maze(rgb_maze), .rgb_scare(rgb_scare), .rgb_win(rgb_win),
        .rgb_out(rgb_out), .title_color(title_color), .state(state), .level(level)
    );

    always #5 clk = ~clk;

    // Behavioural model: screen index 0..3, ticks seen since entering the screen,
    // ticks seen in the current colour period.
    int m_state, m_level, m_ticks, m_cticks, m_color, m_rgb;
    bit m_btn_q, m_armed;
    int n_state, n_level, n_ticks, n_cticks, n_color, n_rgb;
    bit n_armed;

    function automatic int source(input int scr);
        case (scr)
            0:       return int'(rgb_title);
            1:       return int'(rgb_maze);
            2:       return int'(rgb_scare);
            default: return int'(rgb_win);
        endcase
    endfunction

    always_comb begin
        n_state  = m_state;
        n_level  = m_level;
        n_armed  = m_armed || !goal_reached;
        n_cticks = m_cticks;
        n_color  = m_color;
        case (m_state)
            0: if (btn_start && !m_btn_q) begin n_state = 1; n_level = 0; end
            1: if (collision) n_state = 2;
               else if (goal_reached && m_armed) begin
                   n_armed = 0;
                   if (m_level + 1 < LEVELS) n_level = m_level + 1;
                   else n_state = 3;
               end
            2: if (frame_tick && m_ticks + 1 == FRAMES_SCARE) begin n_state = 0; n_level = 0; end
            default: if (frame_tick && m_ticks + 1 == FRAMES_WIN) begin n_state = 0; n_level = 0; end
        endcase
        if (n_state != m_state) n_ticks = 0;
        else if (frame_tick) n_ticks = (m_ticks >= 255) ? 255 : m_ticks + 1;
        else n_ticks = m_ticks;
        if (m_state != 0) n_cticks = 0;
        else if (frame_tick) begin
            if (m_cticks + 1 == COLOR_FRAMES) begin
                n_cticks = 0;
                n_color  = (m_color % 7) + 1;
            end else n_cticks = m_cticks + 1;
        end
        n_rgb = video_on ? source(m_state) : 0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0; m_level <= 0; m_ticks <= 0; m_cticks <= 0;
            m_color <= 1; m_rgb <= 0; m_btn_q <= 0; m_armed <= 1;
        end else begin
            m_state <= n_state; m_level <= n_level; m_ticks <= n_ticks; m_cticks <= n_cticks;
            m_color <= n_color; m_rgb <= n_rgb; m_btn_q <= btn_start; m_armed <= n_armed;
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int exp_col[8] = '{2, 3, 4, 5, 6, 7, 1, 2};

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    chk("state", int'(state), m_state);
                    chk("level", int'(level), m_level);
                    chk("title_color", int'(title_color), m_color);
                    chk("rgb_out", int'(rgb_out), m_rgb);
                    chk("title_color_nonzero", int'(title_color != 3'd0), 1);
                end
            end
            begin
                #5ms;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset then start
        cyc(); cyc();
        chk("rst_state", int'(state), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_color", int'(title_color), 1);
        chk("rst_rgb", int'(rgb_out), 0);
        reset = 0; cyc();
        btn_start = 1; cyc();
        chk("start_state", int'(state), 1);
        chk("start_level", int'(level), 0);
        cyc(); cyc();
        chk("held_state", int'(state), 1);
        btn_start = 0; cyc();

        // Level progression, one increment per high period
        goal_reached = 1; cyc();
        chk("goal1_level", int'(level), 1);
        repeat (4) cyc();
        chk("goal1_held_level", int'(level), 1);
        goal_reached = 0; cyc();
        goal_reached = 1; cyc();
        chk("goal2_level", int'(level), 2);
        goal_reached = 0; cyc();
        goal_reached = 1; cyc();
        chk("win_state", int'(state), 3);
        goal_reached = 0;

        // Win hold
        frame_tick = 1;
        repeat (FRAMES_WIN - 1) cyc();
        chk("win_hold_state", int'(state), 3);
        cyc();
        chk("win_exit_state", int'(state), 0);
        chk("win_exit_level", int'(level), 0);
        chk("model_win_exit", m_state, 0);
        frame_tick = 0;

        // Collision priority and scare hold
        btn_start = 1; cyc(); btn_start = 0;
        chk("restart_state", int'(state), 1);
        goal_reached = 1; cyc(); goal_reached = 0; cyc();
        chk("pre_scare_level", int'(level), 1);
        collision = 1; goal_reached = 1; cyc();
        chk("scare_state", int'(state), 2);
        chk("scare_level", int'(level), 1);
        collision = 0; goal_reached = 0;
        frame_tick = 1;
        repeat (FRAMES_SCARE - 1) cyc();
        chk("scare_hold_state", int'(state), 2);
        cyc();
        chk("scare_exit_state", int'(state), 0);
        chk("scare_exit_level", int'(level), 0);
        chk("model_scare_exit", m_level, 0);
        frame_tick = 0; cyc();

        // Title colour cycle
        for (int k = 1; k <= 240; k++) begin
            frame_tick = 1; cyc();
            frame_tick = 0; cyc();
            if (k % 30 == 0) chk($sformatf("color_tick%0d", k), int'(title_color), exp_col[k/30-1]);
        end
        chk("model_color_240", m_color, 2);

        // RGB mux
        rgb_title = 3'b101; rgb_maze = 3'b010; rgb_scare = 3'b011; rgb_win = 3'b110;
        video_on = 1; cyc();
        chk("mux_title", int'(rgb_out), 5);
        video_on = 0; cyc();
        chk("mux_blank", int'(rgb_out), 0);
        video_on = 1; btn_start = 1; cyc();
        chk("mux_switch_state", int'(state), 1);
        chk("mux_switch_old_src", int'(rgb_out), 5);
        btn_start = 0; cyc();
        chk("mux_maze", int'(rgb_out), 2);

        // Reset mid-scare
        collision = 1; cyc(); collision = 0;
        chk("mid_scare_state", int'(state), 2);
        frame_tick = 1; repeat (50) cyc(); frame_tick = 0;
        chk("mid_scare_rgb", int'(rgb_out), 3);
        reset = 1; #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_rgb", int'(rgb_out), 0);
        chk("async_rst_color", int'(title_color), 1);
        cyc(); reset = 0;
        frame_tick = 1; repeat (80) cyc(); frame_tick = 0;
        chk("no_resume_state", int'(state), 0);

        // Randomized run against the model
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 2999) == 0) begin
                reset = 1; #2; reset = 0;
            end
            if ($urandom_range(0, 3) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 4) == 0) goal_reached = ~goal_reached;
            collision  = ($urandom_range(0, 59) == 0);
            frame_tick = 1'($urandom_range(0, 1));
            video_on   = 1'($urandom_range(0, 1));
            rgb_title  = 3'($urandom); rgb_maze = 3'($urandom);
            rgb_scare  = 3'($urandom); rgb_win  = 3'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level screen controller for the maze game. It sequences the display through title, play, scare and win screens and selects which pixel generator drives the VGA RGB output. It also schedules the title-text colour cycle on frame boundaries. It sits between the VGA sync generator, the four RGB generators (title, maze, scare image, win image) and the board's RGB pins.

## Interface
Parameters:
- `FRAMES_SCARE`, default 120: frames the scare screen is held (2 s at 60 Hz); legal range 1..255.
- `FRAMES_WIN`, default 180: frames the win screen is held; legal range 1..255.
- `COLOR_FRAMES`, default 30: frames per title-colour step; legal range 1..255.
- `LEVELS`, default 3: number of maze levels per game; legal range 1..4.

Ports:
- `clk`, in, 1: system pixel-domain clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse once per frame, from the sync generator at start of vertical blank.
- `btn_start`, in, 1: start button, already synchronized and debounced (level).
- `collision`, in, 1: player touches a wall (level, from the maze generator).
- `goal_reached`, in, 1: player on the goal tile (level).
- `video_on`, in, 1: active display area.
- `rgb_title`, in, 3: title generator pixel.
- `rgb_maze`, in, 3: maze generator pixel.
- `rgb_scare`, in, 3: scare generator pixel.
- `rgb_win`, in, 3: win generator pixel.
- `rgb_out`, out, 3: registered pixel to the pins.
- `title_color`, out, 3: current colour for the title text.
- `state`, out, 2: screen code. TITLE=00, PLAY=01, SCARE=10, WIN=11.
- `level`, out, 2: current maze level, 0..LEVELS-1.

## Operation
- **Start edge.** `start_edge` = `btn_start` & ~`btn_start_q`, where `btn_start_q` is a register. Holding the button never produces a second edge.
- **Frame counter.** 8-bit `fcnt`. It clears on every state change. Otherwise it increments on `frame_tick`, saturating at 255.
- **TITLE:**
  - `start_edge` moves to PLAY with `level`=0.
  - `collision` and `goal_reached` are ignored.
- **PLAY:**
  - `collision`=1 moves to SCARE.
  - Otherwise, `goal_reached`=1 has two cases:
    - If `level`<LEVELS-1: increment `level` and stay in PLAY. The goal is re-armed only after `goal_reached` is seen low for at least one cycle, so one goal gives one increment.
    - If `level`=LEVELS-1: move to WIN.
  - If both inputs are high in the same cycle, collision wins.
  - `btn_start` is ignored.
- **SCARE:** on a `frame_tick` when `fcnt`=FRAMES_SCARE-1, move to TITLE and set `level`=0. No input aborts the scare.
- **WIN:** on a `frame_tick` when `fcnt`=FRAMES_WIN-1, move to TITLE and set `level`=0.
- **Title colour:**
  - A separate 8-bit `ccnt` counts `frame_tick`s only while in TITLE.
  - When `ccnt`=COLOR_FRAMES-1 on a tick, `ccnt` clears and `title_color` advances 1→2→…→7→1. Value 0 (black) is never produced.
  - On entering TITLE, `ccnt` clears; `title_color` keeps its value.
- **RGB mux:**
  - `rgb_out` is registered: 000 when `video_on`=0.
  - Otherwise it selects `rgb_title`, `rgb_maze`, `rgb_scare` or `rgb_win` according to the current `state`.

## Timing
- **Reset values (asynchronous, immediate):**
  - `state`=TITLE, `level`=0, `title_color`=001, `rgb_out`=000.
  - `fcnt`=0, `ccnt`=0, `btn_start_q`=0, goal re-arm flag = armed.
- **Transition latency:** all transitions take effect on the first `clk` edge at which the condition is sampled true. `state` and `level` update on that same edge.
- **RGB latency:** 1 clock from `video_on`/`rgb_*` to `rgb_out`. The source select uses the registered `state` from the same cycle, so a state change is reflected in the next pixel.
- **Hold durations:** exactly FRAMES_SCARE (or FRAMES_WIN) `frame_tick`s after entry. The tick that causes the exit is the last counted one.
- **Simultaneous events:**
  - A `frame_tick` in the same cycle as a PLAY→SCARE transition is not counted in SCARE, because `fcnt` clears on the state change.
  - A `start_edge` in the same cycle as SCARE/WIN→TITLE is ignored; a new press is required.
- **Reset mid-operation:** any state aborts to TITLE at once. No output glitch is required beyond the asynchronous clear.

## Test plan
- **Reset then start.** Assert `reset`, then release; pulse `btn_start` for 3 cycles. Required: `state`=00, `title_color`=001 after reset; `state`=01 and `level`=0 one cycle after the rising edge; no further transition while the button is held.
- **Level progression.** In PLAY, drive `goal_reached` high 5 cycles, low, high, low, high. Required: `level` goes 0→1→2, then `state`=11. Each high period yields exactly one increment.
- **Collision priority and scare hold.** In PLAY, raise `collision` and `goal_reached` in the same cycle. Required: `state`=10 and `level` unchanged. After exactly 120 `frame_tick`s, `state`=00 and `level`=0.
- **Title colour cycle.** Stay in TITLE for 240 `frame_tick`s with default parameters. Required: `title_color` steps 1,2,…,7,1,2 at ticks 30,60,…,240; never 000.
- **RGB mux.** With `rgb_title`=101 and `rgb_maze`=010, toggle `video_on` and change `state`. Required: `rgb_out` shows 000 one cycle after `video_on`=0, otherwise the selected source one cycle later.
- **Reset mid-operation.** During SCARE (`fcnt`=50), pulse `reset`. Required: immediate `state`=00, `rgb_out`=000, `title_color`=001. After release, the scare does not resume.
